// File: rtl/pc_counter.sv
// Program counter register: reset > STALL > LOAD > INC > hold, one-cycle latency.
// STALL freezes both OUT and WRAP; there is no other backpressure.
module pc_counter #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             STALL,
  input  logic             LOAD,
  input  logic             INC,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] OUT,
  output logic             WRAP
);

  logic [WIDTH:0] inc_sum;

  // Carry-out of the increment is the wrap indication.
  assign inc_sum = {1'b0, OUT} + {{WIDTH{1'b0}}, 1'b1};

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUT  <= RESET_VAL;
      WRAP <= 1'b0;
    end else if (STALL) begin
      OUT  <= OUT;
      WRAP <= WRAP;
    end else if (LOAD) begin
      OUT  <= IN;
      WRAP <= 1'b0;
    end else if (INC) begin
      OUT  <= inc_sum[WIDTH-1:0];
      WRAP <= inc_sum[WIDTH];
    end else begin
      OUT  <= OUT;
      WRAP <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_counter.sv
// Bench for pc_counter: per-scenario stimulus tables, expected OUT/WRAP queued
// when a vector is driven and compared one edge later.
module tb_pc_counter;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         STALL;
  logic         LOAD;
  logic         INC;
  logic [W-1:0] IN;
  logic [W-1:0] OUT;
  logic         WRAP;

  typedef struct packed {
    logic         rst_n;
    logic         stall;
    logic         load;
    logic         inc;
    logic [W-1:0] din;
    logic [W-1:0] eout;
    logic         ewrap;
  } vec_t;

  logic [W:0] sb[$];
  int vectors     = 0;
  int miscompares = 0;

  pc_counter #(.WIDTH(W), .RESET_VAL('0)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .STALL(STALL),
    .LOAD (LOAD),
    .INC  (INC),
    .IN   (IN),
    .OUT  (OUT),
    .WRAP (WRAP)
  );

  always #5 CLK = ~CLK;

  // Drive one vector on the falling edge, queue its expectation, then step past
  // the rising edge so the caller samples one time unit after it.
  task automatic apply(input vec_t v);
    @(negedge CLK);
    RST_N = v.rst_n;
    STALL = v.stall;
    LOAD  = v.load;
    INC   = v.inc;
    IN    = v.din;
    sb.push_back({v.eout, v.ewrap});
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    vec_t vq[$];
    logic [W:0] exp;
    vq.push_back('{rst_n:1'b0, stall:1'b1, load:1'b1, inc:1'b1, din:16'hFFFF, eout:16'h0000, ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL reset[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_count();
    vec_t vq[$];
    logic [W:0] exp;
    for (int k = 1; k <= 5; k++)
      vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h5A5A, eout:W'(k), ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL count[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_load_priority();
    vec_t vq[$];
    logic [W:0] exp;
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b1, din:16'h1234, eout:16'h1234, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b0, din:16'h9999, eout:16'h1234, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'h8000, eout:16'h8000, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h8001, ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL load_prio[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_wrap();
    vec_t vq[$];
    logic [W:0] exp;
    // Loading all-ones alone must not flag a wrap.
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'hFFFF, eout:16'hFFFF, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0000, ewrap:1'b1});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b0, din:16'h0000, eout:16'h0000, ewrap:1'b0});
    // Wrap pulse held through a stall, then cleared by an increment.
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'hFFFF, eout:16'hFFFF, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0000, ewrap:1'b1});
    vq.push_back('{rst_n:1'b1, stall:1'b1, load:1'b1, inc:1'b1, din:16'h7777, eout:16'h0000, ewrap:1'b1});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0001, ewrap:1'b0});
    // A load on the cycle after a wrap clears WRAP too.
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'hFFFF, eout:16'hFFFF, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0000, ewrap:1'b1});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'h0ABC, eout:16'h0ABC, ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_stall();
    vec_t vq[$];
    logic [W:0] exp;
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'h0010, eout:16'h0010, ewrap:1'b0});
    for (int k = 0; k < 3; k++)
      vq.push_back('{rst_n:1'b1, stall:1'b1, load:1'b1, inc:1'b1, din:16'hABCD, eout:16'h0010, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'hABCD, eout:16'h0011, ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL stall[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_reset_override();
    vec_t vq[$];
    logic [W:0] exp;
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'h00FF, eout:16'h00FF, ewrap:1'b0});
    vq.push_back('{rst_n:1'b0, stall:1'b1, load:1'b1, inc:1'b0, din:16'h3333, eout:16'h0000, ewrap:1'b0});
    // Reset landing on the wrap-pulse cycle clears WRAP; next edge is normal.
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'hFFFF, eout:16'hFFFF, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0000, ewrap:1'b1});
    vq.push_back('{rst_n:1'b0, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0000, ewrap:1'b0});
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b1, din:16'h0000, eout:16'h0001, ewrap:1'b0});
    foreach (vq[i]) begin
      apply(vq[i]);
      exp = sb.pop_front();
      vectors++;
      if ({OUT, WRAP} !== exp) begin
        miscompares++;
        $display("FAIL reset_override[%0d]: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", i, OUT, WRAP, exp[W:1], exp[0]);
      end
    end
  endtask

  task automatic test_sync_reset_glitch();
    vec_t vq[$];
    logic [W:0] exp;
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b1, inc:1'b0, din:16'h0042, eout:16'h0042, ewrap:1'b0});
    apply(vq[0]);
    exp = sb.pop_front();
    vectors++;
    if ({OUT, WRAP} !== exp) begin
      miscompares++;
      $display("FAIL glitch_setup: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", OUT, WRAP, exp[W:1], exp[0]);
    end
    LOAD  = 1'b0;
    #1 RST_N = 1'b0;
    #2;
    vectors++;
    if (OUT !== 16'h0042) begin
      miscompares++;
      $display("FAIL glitch_mid: got OUT=%h, want OUT=0042", OUT);
    end
    RST_N = 1'b1;
    vq.push_back('{rst_n:1'b1, stall:1'b0, load:1'b0, inc:1'b0, din:16'h0000, eout:16'h0042, ewrap:1'b0});
    apply(vq[1]);
    exp = sb.pop_front();
    vectors++;
    if ({OUT, WRAP} !== exp) begin
      miscompares++;
      $display("FAIL glitch_after_edge: got OUT=%h WRAP=%b, want OUT=%h WRAP=%b", OUT, WRAP, exp[W:1], exp[0]);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    RST_N = 1'b1;
    STALL = 1'b0;
    LOAD  = 1'b0;
    INC   = 1'b0;
    IN    = '0;
    test_reset();
    test_count();
    test_load_priority();
    test_wrap();
    test_stall();
    test_reset_override();
    test_sync_reset_glitch();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
